// File: rtl/simon_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : simon_sequencer
//  Purpose  : Memory-game sequencer. Grows a pattern of random 4-bit codes by
//             one code per round, plays it back as timed LED flashes, then
//             checks the player's entries. Flags a win at full pattern length
//             and a fail on the first wrong entry.
//  Revision : 1.0 - initial release
// ============================================================================
module simon_sequencer #(
   parameter int MAX_LEN    = 16,
   parameter int SHOW_TICKS = 25_000_000,
   parameter int GAP_TICKS  = 12_500_000
) (
   input  logic       posclk,
   input  logic       rst,
   input  logic [3:0] rnd,
   input  logic       start,
   input  logic       btn_valid,
   input  logic [3:0] btn_code,
   output logic [3:0] led_idx,
   output logic       led_on,
   output logic       await_input,
   output logic [4:0] level,
   output logic       win,
   output logic       fail
);

   // Timer only has to reach (ticks - 1), so clog2 of the larger count suffices.
   localparam int c_MAX_TICKS = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int c_TIMER_W   = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;
   localparam int c_IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [c_TIMER_W-1:0] c_SHOW_LAST = c_TIMER_W'(SHOW_TICKS - 1);
   localparam logic [c_TIMER_W-1:0] c_GAP_LAST  = c_TIMER_W'(GAP_TICKS - 1);
   localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);
   localparam logic [4:0]           c_MAX_LEVEL = 5'(MAX_LEN);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_APPEND   = 3'd1;
   localparam logic [2:0] S_SHOW_ON  = 3'd2;
   localparam logic [2:0] S_SHOW_OFF = 3'd3;
   localparam logic [2:0] S_WAIT_IN  = 3'd4;
   localparam logic [2:0] S_WIN      = 3'd5;
   localparam logic [2:0] S_FAIL     = 3'd6;

   logic [2:0]           r_state;
   logic [3:0]           r_mem [0:MAX_LEN-1];
   logic [3:0]           r_play_ptr;
   logic [3:0]           r_in_ptr;
   logic [4:0]           r_level;
   logic [c_TIMER_W-1:0] r_timer;

   logic [4:0] w_last_idx;
   logic       w_play_last;
   logic       w_in_last;
   logic       w_show_done;
   logic       w_gap_done;
   logic       w_entry_ok;
   logic [3:0] w_play_code;

   // Index of the newest code in the pattern; only meaningful once level >= 1.
   assign w_last_idx  = r_level - 5'd1;
   assign w_play_last = ({1'b0, r_play_ptr} == w_last_idx);
   assign w_in_last   = ({1'b0, r_in_ptr} == w_last_idx);
   assign w_show_done = (r_timer == c_SHOW_LAST);
   assign w_gap_done  = (r_timer == c_GAP_LAST);
   assign w_play_code = r_mem[r_play_ptr[c_IDX_W-1:0]];
   assign w_entry_ok  = (btn_code == r_mem[r_in_ptr[c_IDX_W-1:0]]);

   // Pattern memory: append-only, written once per round at the next free slot.
   always_ff @(posedge posclk) begin
      if (!rst && (r_state == S_APPEND)) begin
         r_mem[r_level[c_IDX_W-1:0]] <= rnd;
      end
   end

   // Game control FSM with playback timer, pointers and level counter.
   always_ff @(posedge posclk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_play_ptr <= 4'd0;
         r_in_ptr   <= 4'd0;
         r_level    <= 5'd0;
         r_timer    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_level <= 5'd0;
                  r_state <= S_APPEND;
               end
            end
            S_APPEND: begin
               r_level    <= r_level + 5'd1;
               r_play_ptr <= 4'd0;
               r_timer    <= '0;
               r_state    <= S_SHOW_ON;
            end
            S_SHOW_ON: begin
               if (w_show_done) begin
                  r_timer <= '0;
                  r_state <= S_SHOW_OFF;
               end else begin
                  r_timer <= r_timer + c_TIMER_ONE;
               end
            end
            S_SHOW_OFF: begin
               if (w_gap_done) begin
                  r_timer <= '0;
                  if (w_play_last) begin
                     r_in_ptr <= 4'd0;
                     r_state  <= S_WAIT_IN;
                  end else begin
                     r_play_ptr <= r_play_ptr + 4'd1;
                     r_state    <= S_SHOW_ON;
                  end
               end else begin
                  r_timer <= r_timer + c_TIMER_ONE;
               end
            end
            S_WAIT_IN: begin
               if (btn_valid) begin
                  if (!w_entry_ok) begin
                     r_state <= S_FAIL;
                  end else if (!w_in_last) begin
                     r_in_ptr <= r_in_ptr + 4'd1;
                  end else if (r_level == c_MAX_LEVEL) begin
                     r_state <= S_WIN;
                  end else begin
                     // Straight into the next round: no extra gap before its playback.
                     r_state <= S_APPEND;
                  end
               end
            end
            S_WIN, S_FAIL: begin
               if (start) begin
                  r_level <= 5'd0;
                  r_state <= S_APPEND;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Moore outputs decoded purely from registered state.
   assign led_on      = (r_state == S_SHOW_ON);
   assign led_idx     = led_on ? w_play_code : 4'd0;
   assign await_input = (r_state == S_WAIT_IN);
   assign level       = r_level;
   assign win         = (r_state == S_WIN);
   assign fail        = (r_state == S_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_simon_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_sequencer
//  Purpose  : Self-checking bench for simon_sequencer. A game-level model
//             (pattern queue, entry index) predicts every output cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simon_sequencer;

   localparam int MAXL = 3;
   localparam int SHOW = 3;
   localparam int GAP  = 2;

   localparam int O_CONT = 0;
   localparam int O_NEXT = 1;
   localparam int O_WON  = 2;
   localparam int O_LOST = 3;

   logic       posclk = 1'b0;
   logic       rst;
   logic [3:0] rnd;
   logic       start;
   logic       btn_valid;
   logic [3:0] btn_code;
   logic [3:0] led_idx;
   logic       led_on;
   logic       await_input;
   logic [4:0] level;
   logic       win;
   logic       fail;

   int checks   = 0;
   int failures = 0;

   logic [3:0] pat[$];
   int         in_idx;

   always #5 posclk = ~posclk;

   simon_sequencer #(
      .MAX_LEN   (MAXL),
      .SHOW_TICKS(SHOW),
      .GAP_TICKS (GAP)
   ) u_dut (
      .posclk     (posclk),
      .rst        (rst),
      .rnd        (rnd),
      .start      (start),
      .btn_valid  (btn_valid),
      .btn_code   (btn_code),
      .led_idx    (led_idx),
      .led_on     (led_on),
      .await_input(await_input),
      .level      (level),
      .win        (win),
      .fail       (fail)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge posclk);
      @(negedge posclk);
   endtask

   task automatic chk_quiet(input string tag, input int lvl, input bit w, input bit f);
      chk({tag, ".led_on"}, 32'(led_on), 0);
      chk({tag, ".led_idx"}, 32'(led_idx), 0);
      chk({tag, ".await"}, 32'(await_input), 0);
      chk({tag, ".level"}, 32'(level), lvl);
      chk({tag, ".win"}, 32'(win), 32'(w));
      chk({tag, ".fail"}, 32'(fail), 32'(f));
   endtask

   // start -> one APPEND cycle (level 0) -> first SHOW_ON cycle with level 1.
   task automatic begin_game(input logic [3:0] code);
      start = 1'b1;
      rnd   = code;
      step();
      start = 1'b0;
      chk_quiet("append0", 0, 1'b0, 1'b0);
      step();
      pat.delete();
      pat.push_back(code);
   endtask

   // Whole playback: each code lit SHOW cycles then dark GAP cycles; ignored
   // btn/start pulses are sprinkled throughout.
   task automatic playback();
      int n;
      n = pat.size();
      for (int i = 0; i < n; i++) begin
         for (int t = 0; t < SHOW; t++) begin
            chk("show.led_on", 32'(led_on), 1);
            chk("show.led_idx", 32'(led_idx), 32'(pat[i]));
            chk("show.await", 32'(await_input), 0);
            chk("show.level", 32'(level), n);
            btn_valid = 1'($urandom_range(0, 1));
            btn_code  = 4'($urandom);
            start     = 1'($urandom_range(0, 1));
            step();
         end
         for (int t = 0; t < GAP; t++) begin
            chk("gap.led_on", 32'(led_on), 0);
            chk("gap.led_idx", 32'(led_idx), 0);
            chk("gap.await", 32'(await_input), 0);
            chk("gap.level", 32'(level), n);
            btn_valid = 1'($urandom_range(0, 1));
            btn_code  = 4'($urandom);
            start     = 1'($urandom_range(0, 1));
            step();
         end
      end
      btn_valid = 1'b0;
      start     = 1'b0;
      chk("ready.await", 32'(await_input), 1);
      chk("ready.led_on", 32'(led_on), 0);
      chk("ready.level", 32'(level), n);
      in_idx = 0;
   endtask

   // One player entry; the model decides the outcome and checks the DUT reaction.
   task automatic enter(input logic [3:0] code, input logic [3:0] nxt, output int outcome);
      int n;
      n = pat.size();
      chk("entry.pre_await", 32'(await_input), 1);
      btn_valid = 1'b1;
      btn_code  = code;
      step();
      btn_valid = 1'b0;
      if (code != pat[in_idx]) begin
         chk_quiet("wrong", n, 1'b0, 1'b1);
         outcome = O_LOST;
      end else if (in_idx < n - 1) begin
         in_idx++;
         chk("cont.await", 32'(await_input), 1);
         chk("cont.level", 32'(level), n);
         chk("cont.fail", 32'(fail), 0);
         outcome = O_CONT;
      end else if (n == MAXL) begin
         chk_quiet("won", n, 1'b1, 1'b0);
         outcome = O_WON;
      end else begin
         chk_quiet("append", n, 1'b0, 1'b0);
         rnd = nxt;
         step();
         pat.push_back(nxt);
         playback();
         outcome = O_NEXT;
      end
   endtask

   // Game over: button presses must leave the end state untouched.
   task automatic after_end(input bit w, input bit f);
      for (int i = 0; i < 3; i++) begin
         btn_valid = 1'b1;
         btn_code  = 4'($urandom);
         step();
         chk_quiet("end_hold", pat.size(), w, f);
      end
      btn_valid = 1'b0;
   endtask

   initial begin
      int         o;
      logic [3:0] c;
      rst       = 1'b1;
      start     = 1'b0;
      btn_valid = 1'b0;
      rnd       = 4'd0;
      btn_code  = 4'd0;
      @(negedge posclk);
      step();
      chk_quiet("reset", 0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_quiet("idle", 0, 1'b0, 1'b0);

      // Reset in the middle of SHOW_ON; second reset cycle also carries start.
      begin_game(4'hA);
      chk("r1.led_on", 32'(led_on), 1);
      step();
      rst = 1'b1;
      step();
      chk_quiet("midreset", 0, 1'b0, 1'b0);
      start = 1'b1;
      step();
      chk_quiet("rst_vs_start", 0, 1'b0, 1'b0);
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk_quiet("post_reset", 0, 1'b0, 1'b0);

      // Directed progression up to a win at full length.
      begin_game(4'hA);
      playback();
      enter(4'hA, 4'h5, o);
      chk("prog.l2", 32'(o), O_NEXT);
      enter(4'hA, 4'h0, o);
      enter(4'h5, 4'($urandom), o);
      chk("prog.l3", 32'(level), 3);
      for (int i = 0; i < MAXL; i++) enter(pat[i], 4'h0, o);
      chk("prog.won", 32'(o), O_WON);
      after_end(1'b1, 1'b0);

      // Restart from WIN, start pulses in WAIT_IN, then a wrong entry.
      begin_game(4'hA);
      playback();
      enter(4'hA, 4'h5, o);
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      chk("wait_start.await", 32'(await_input), 1);
      chk("wait_start.level", 32'(level), 2);
      enter(4'hA, 4'h0, o);
      enter(4'h7, 4'h0, o);
      chk("fail.outcome", 32'(o), O_LOST);
      after_end(1'b0, 1'b1);

      // Randomized games, restarting from whichever end state the last one left.
      for (int g = 0; g < 6; g++) begin
         begin_game(4'($urandom));
         playback();
         o = O_CONT;
         while (o == O_CONT || o == O_NEXT) begin
            c = pat[in_idx];
            if ($urandom_range(0, 6) == 0) c = c ^ 4'($urandom_range(1, 15));
            enter(c, 4'($urandom), o);
         end
         after_end(o == O_WON, o == O_LOST);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
